// File: rtl/ad9361x2_ensm_sequencer.sv
// Pin-mode ENSM sequencer for the two AD9361 devices on FMCOMMS5.
// Drives ENABLE/TXNRX of both chips with an enable-low gap before any
// TXNRX change and a TXNRX setup time before ENABLE rises. Commands may be
// aligned to a tdd_sync event, generated here (master) or received (slave).
// Optional build macro AD9361X2_ENSM_SYNC_TIMEOUT_EN: slave sync wait gives
// up after SYNC_TIMEOUT cycles, raising err and completing without pin changes.
module ad9361x2_ensm_sequencer #(
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned SETUP_CYCLES   = 8,
    parameter int unsigned SYNC_PULSE_LEN = 4,
    parameter int unsigned SYNC_TIMEOUT   = 65536
) (
    input  logic       axi_aclk,
    input  logic       axi_areset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_enable,
    input  logic       cmd_txnrx,
    input  logic [1:0] cmd_mask,
    input  logic       cmd_sync,
    input  logic       cmd_sync_master,
    output logic       enable_0,
    output logic       txnrx_0,
    output logic       enable_1,
    output logic       txnrx_1,
    input  logic       tdd_sync_i,
    output logic       tdd_sync_o,
    output logic       tdd_sync_t,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned MAX_A = (GAP_CYCLES > SETUP_CYCLES) ? GAP_CYCLES : SETUP_CYCLES;
    localparam int unsigned MAX_B = (MAX_A > SYNC_PULSE_LEN) ? MAX_A : SYNC_PULSE_LEN;
    localparam int unsigned MAX_C = (MAX_B > SYNC_TIMEOUT) ? MAX_B : SYNC_TIMEOUT;
    localparam int unsigned CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_SYNC = 3'd1,
        DISABLE   = 3'd2,
        SETUP     = 3'd3,
        FINISH    = 3'd4
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [1:0]         en_q, en_n, tx_q, tx_n;
    logic               sync_o_q, sync_o_n, sync_t_q, sync_t_n;
    logic               ready_q, busy_q, done_q, done_n, err_q, err_n;
    logic               lat_enable, lat_txnrx, lat_master;
    logic [1:0]         lat_mask;
    logic               sync_meta, sync_sync, sync_dly, sync_rise;
    logic               accept, do_apply, dec_txnrx;
    logic [1:0]         dec_mask;

    assign accept    = (state == IDLE) && cmd_valid;
    assign sync_rise = sync_sync & ~sync_dly;

    // Two-flop synchronizer plus one delay stage for rising-edge detection
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            sync_meta <= 1'b0;
            sync_sync <= 1'b0;
            sync_dly  <= 1'b0;
        end else begin
            sync_meta <= tdd_sync_i;
            sync_sync <= sync_meta;
            sync_dly  <= sync_sync;
        end
    end

    // Next state, counter and next values of every registered output
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        en_n      = en_q;
        tx_n      = tx_q;
        sync_o_n  = 1'b0;
        sync_t_n  = 1'b1;
        done_n    = 1'b0;
        err_n     = err_q;
        do_apply  = 1'b0;
        dec_mask  = lat_mask;
        dec_txnrx = lat_txnrx;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    err_n     = 1'b0;
                    dec_mask  = cmd_mask;
                    dec_txnrx = cmd_txnrx;
                    if (cmd_mask == 2'b00) begin
                        state_n = FINISH;
                        done_n  = 1'b1;
                    end else if (cmd_sync) begin
                        state_n = WAIT_SYNC;
                        if (cmd_sync_master) begin
                            sync_o_n = 1'b1;
                            sync_t_n = 1'b0;
                            cnt_n    = CNT_W'(SYNC_PULSE_LEN - 1);
                        end else begin
                            cnt_n    = CNT_W'(SYNC_TIMEOUT - 1);
                        end
                    end else begin
                        do_apply = 1'b1;
                    end
                end
            end
            WAIT_SYNC: begin
                if (lat_master) begin
                    if (cnt != '0) begin
                        sync_o_n = 1'b1;
                        sync_t_n = 1'b0;
                        cnt_n    = cnt - CNT_W'(1);
                    end else begin
                        do_apply = 1'b1;
                    end
                end else if (sync_rise) begin
                    do_apply = 1'b1;
`ifdef AD9361X2_ENSM_SYNC_TIMEOUT_EN
                end else if (cnt == '0) begin
                    state_n = FINISH;
                    done_n  = 1'b1;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
`endif
                end
            end
            DISABLE: begin
                if (cnt == '0) begin
                    state_n = SETUP;
                    tx_n    = (tx_q & ~lat_mask) | (lat_mask & {2{lat_txnrx}});
                    cnt_n   = CNT_W'(SETUP_CYCLES - 1);
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_n = FINISH;
                    en_n    = (en_q & ~lat_mask) | (lat_mask & {2{lat_enable}});
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Apply decision: drop any enabled masked chip first, else go straight to setup
        if (do_apply) begin
            if ((dec_mask & en_q) != 2'b00) begin
                state_n = DISABLE;
                en_n    = en_q & ~dec_mask;
                cnt_n   = CNT_W'(GAP_CYCLES - 1);
            end else begin
                state_n = SETUP;
                tx_n    = (tx_q & ~dec_mask) | (dec_mask & {2{dec_txnrx}});
                cnt_n   = CNT_W'(SETUP_CYCLES - 1);
            end
        end
    end

    // State, counter, output and command-latch registers
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state      <= IDLE;
            cnt        <= '0;
            en_q       <= 2'b00;
            tx_q       <= 2'b00;
            sync_o_q   <= 1'b0;
            sync_t_q   <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            lat_enable <= 1'b0;
            lat_txnrx  <= 1'b0;
            lat_master <= 1'b0;
            lat_mask   <= 2'b00;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            en_q     <= en_n;
            tx_q     <= tx_n;
            sync_o_q <= sync_o_n;
            sync_t_q <= sync_t_n;
            ready_q  <= (state_n == IDLE);
            busy_q   <= (state_n != IDLE);
            done_q   <= done_n;
            err_q    <= err_n;
            if (accept) begin
                lat_enable <= cmd_enable;
                lat_txnrx  <= cmd_txnrx;
                lat_master <= cmd_sync_master;
                lat_mask   <= cmd_mask;
            end
        end
    end

    assign cmd_ready  = ready_q;
    assign enable_0   = en_q[0];
    assign enable_1   = en_q[1];
    assign txnrx_0    = tx_q[0];
    assign txnrx_1    = tx_q[1];
    assign tdd_sync_o = sync_o_q;
    assign tdd_sync_t = sync_t_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_ad9361x2_ensm_sequencer.sv
// Directed self-checking bench for ad9361x2_ensm_sequencer.
// Pin vector order used in checks: {enable_1, txnrx_1, enable_0, txnrx_0}.
module tb_ad9361x2_ensm_sequencer;

`ifdef AD9361X2_ENSM_SYNC_TIMEOUT_EN
    localparam int EDGE_DLY = 30;
`else
    localparam int EDGE_DLY = 100;
`endif

    logic       axi_aclk = 1'b0;
    logic       axi_areset;
    logic       cmd_valid, cmd_ready, cmd_enable, cmd_txnrx, cmd_sync, cmd_sync_master;
    logic [1:0] cmd_mask;
    logic       enable_0, txnrx_0, enable_1, txnrx_1;
    logic       tdd_sync_i, tdd_sync_o, tdd_sync_t;
    logic       busy, done, err;

    int checks   = 0;
    int failures = 0;
    int nacc, ndone, first_k, second_k;
    logic pend;

    always #5 axi_aclk = ~axi_aclk;

    ad9361x2_ensm_sequencer #(
        .GAP_CYCLES(16), .SETUP_CYCLES(8), .SYNC_PULSE_LEN(4), .SYNC_TIMEOUT(50)
    ) dut (
        .axi_aclk(axi_aclk), .axi_areset(axi_areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_enable(cmd_enable),
        .cmd_txnrx(cmd_txnrx), .cmd_mask(cmd_mask), .cmd_sync(cmd_sync),
        .cmd_sync_master(cmd_sync_master),
        .enable_0(enable_0), .txnrx_0(txnrx_0), .enable_1(enable_1), .txnrx_1(txnrx_1),
        .tdd_sync_i(tdd_sync_i), .tdd_sync_o(tdd_sync_o), .tdd_sync_t(tdd_sync_t),
        .busy(busy), .done(done), .err(err)
    );

    function automatic logic [31:0] b(input logic x);
        return {31'b0, x};
    endfunction

    function automatic logic [31:0] pins();
        return {28'b0, enable_1, txnrx_1, enable_0, txnrx_0};
    endfunction

    function automatic logic [31:0] sync_ot();
        return {30'b0, tdd_sync_o, tdd_sync_t};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge axi_aclk);
        #1;
    endtask

    // Present one command for exactly one edge (the acceptance edge T0)
    task automatic send(input logic en, input logic tx, input logic [1:0] mask,
                        input logic sy, input logic master);
        cmd_enable      = en;
        cmd_txnrx       = tx;
        cmd_mask        = mask;
        cmd_sync        = sy;
        cmd_sync_master = master;
        cmd_valid       = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    initial begin
        axi_areset = 1'b1;
        cmd_valid = 1'b0; cmd_enable = 1'b0; cmd_txnrx = 1'b0; cmd_mask = 2'b00;
        cmd_sync = 1'b0; cmd_sync_master = 1'b0; tdd_sync_i = 1'b0;
        tick(3);
        chk("rst_pins", pins(), 32'b0000);
        chk("rst_sync", sync_ot(), 32'b01);
        chk("rst_ready", b(cmd_ready), 1);
        chk("rst_busy", b(busy), 0);
        chk("rst_done", b(done), 0);
        chk("rst_err", b(err), 0);
        axi_areset = 1'b0;
        tick(2);

        // 1: enables low, no sync -> setup only
        send(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
        chk("t1_t0_pins", pins(), 32'b0000);
        chk("t1_t0_busy", b(busy), 1);
        chk("t1_t0_ready", b(cmd_ready), 0);
        tick(7);
        chk("t1_t7_pins", pins(), 32'b0000);
        chk("t1_t7_done", b(done), 0);
        tick(1);
        chk("t1_t8_pins", pins(), 32'b1010);
        chk("t1_t8_done", b(done), 1);
        tick(1);
        chk("t1_t9_busy", b(busy), 0);
        chk("t1_t9_ready", b(cmd_ready), 1);
        chk("t1_t9_done", b(done), 0);

        // 2: chip 0 enabled -> disable gap, then setup
        send(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
        chk("t2_t0_pins", pins(), 32'b1000);
        tick(15);
        chk("t2_t15_pins", pins(), 32'b1000);
        tick(1);
        chk("t2_t16_pins", pins(), 32'b1001);
        tick(7);
        chk("t2_t23_pins", pins(), 32'b1001);
        tick(1);
        chk("t2_t24_pins", pins(), 32'b1011);
        chk("t2_t24_done", b(done), 1);
        tick(1);

        // 3: master sync on chip 1
        send(1'b1, 1'b1, 2'b10, 1'b1, 1'b1);
        chk("t3_t0_sync", sync_ot(), 32'b10);
        chk("t3_t0_pins", pins(), 32'b1011);
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            chk("t3_pulse_sync", sync_ot(), 32'b10);
            chk("t3_pulse_pins", pins(), 32'b1011);
        end
        tick(1);
        chk("t3_t4_sync", sync_ot(), 32'b01);
        chk("t3_t4_pins", pins(), 32'b0011);
        tick(15);
        chk("t3_t19_pins", pins(), 32'b0011);
        tick(1);
        chk("t3_t20_pins", pins(), 32'b0111);
        tick(8);
        chk("t3_t28_pins", pins(), 32'b1111);
        chk("t3_t28_done", b(done), 1);
        tick(1);

        // 4: slave sync on chip 0, edge arrives later
        send(1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        chk("t4_t0_sync", sync_ot(), 32'b01);
        chk("t4_t0_busy", b(busy), 1);
        tick(EDGE_DLY - 1);
        chk("t4_wait_pins", pins(), 32'b1111);
        chk("t4_wait_busy", b(busy), 1);
        tdd_sync_i = 1'b1;
        tick(1);
        chk("t4_e0_pins", pins(), 32'b1111);
        tick(1);
        chk("t4_e1_pins", pins(), 32'b1111);
        tick(1);
        chk("t4_e2_pins", pins(), 32'b1101);
        tick(16);
        chk("t4_e18_pins", pins(), 32'b1100);
        tick(8);
        chk("t4_e26_pins", pins(), 32'b1110);
        chk("t4_e26_done", b(done), 1);
        tdd_sync_i = 1'b0;
        tick(1);

        // 5: reset during a two-chip disable
        send(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        chk("t5_t0_pins", pins(), 32'b0100);
        tick(5);
        chk("t5_dis_busy", b(busy), 1);
        axi_areset = 1'b1;
        #1;
        chk("t5_rst_pins", pins(), 32'b0000);
        chk("t5_rst_sync", sync_ot(), 32'b01);
        chk("t5_rst_busy", b(busy), 0);
        chk("t5_rst_ready", b(cmd_ready), 1);
        tick(2);
        axi_areset = 1'b0;
        tick(1);
        send(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        chk("t5_re_t0_pins", pins(), 32'b0101);
        tick(7);
        chk("t5_re_t7_pins", pins(), 32'b0101);
        tick(1);
        chk("t5_re_t8_pins", pins(), 32'b1111);
        chk("t5_re_t8_done", b(done), 1);
        tick(1);

`ifdef AD9361X2_ENSM_SYNC_TIMEOUT_EN
        // slave sync with no edge -> timeout
        send(1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
        tick(49);
        chk("to_t49_done", b(done), 0);
        chk("to_t49_err", b(err), 0);
        chk("to_t49_busy", b(busy), 1);
        tick(1);
        chk("to_t50_done", b(done), 1);
        chk("to_t50_err", b(err), 1);
        chk("to_t50_pins", pins(), 32'b1111);
        tick(1);
        chk("to_t51_done", b(done), 0);
        chk("to_t51_err", b(err), 1);
        chk("to_t51_ready", b(cmd_ready), 1);
`endif

        // 6: empty mask completes next cycle without pin changes
        send(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("t6_t0_done", b(done), 1);
        chk("t6_t0_err", b(err), 0);
        chk("t6_t0_pins", pins(), 32'b1111);
        tick(1);
        chk("t6_t1_done", b(done), 0);
        chk("t6_t1_ready", b(cmd_ready), 1);

        // 6b: cmd_valid held high across two full commands
        cmd_enable = 1'b0; cmd_txnrx = 1'b0; cmd_mask = 2'b01;
        cmd_sync = 1'b0; cmd_sync_master = 1'b0; cmd_valid = 1'b1;
        nacc = 0; ndone = 0; first_k = 0; second_k = 0;
        for (int k = 1; k <= 36; k++) begin
            pend = cmd_ready;
            tick(1);
            if (pend) begin
                nacc++;
                if (nacc == 1) first_k = k;
                else if (nacc == 2) second_k = k;
            end
            if (done) ndone++;
        end
        cmd_valid = 1'b0;
        chk("t6b_accepts", 32'(nacc), 2);
        chk("t6b_first", 32'(first_k), 1);
        chk("t6b_second", 32'(second_k), 27);
        chk("t6b_dones", 32'(ndone), 2);
        chk("t6b_pins", pins(), 32'b1100);
        chk("t6b_busy", b(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
